// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock first-word-fall-through FIFO with wrap-bit pointers
// Optional macro SYNC_FIFO_ERR_STICKY_EN adds sticky overflow/underflow flags
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DATA_WIDTH = 39,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       w_push,
    input  logic [DATA_WIDTH-1:0]      w_data,
    output logic                       w_full,
    output logic                       w_almost_full,
    input  logic                       r_pop,
    output logic [DATA_WIDTH-1:0]      r_data,
    output logic                       r_empty,
    output logic                       r_almost_empty,
    output logic [$clog2(DEPTH):0]     count
`ifdef SYNC_FIFO_ERR_STICKY_EN
    ,
    output logic                       err_overflow,
    output logic                       err_underflow
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AF_THR  = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_THR  = PTR_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] PTR_INC = PTR_W'(1);

    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  pop_ok;
    logic                  push_ok;

    assign r_empty = (wptr == rptr);
    assign w_full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                     (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign count   = wptr - rptr;

    assign w_almost_full  = (count >= AF_THR);
    assign r_almost_empty = (count <= AE_THR);

    // A pop in the same cycle frees a slot, so a full FIFO may still take a push.
    assign pop_ok  = r_pop && !r_empty && !flush;
    assign push_ok = w_push && (!w_full || pop_ok) && !flush;

    assign r_data = mem[rptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_INC;
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_INC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[ADDR_W-1:0]] <= w_data;
        end
    end

`ifdef SYNC_FIFO_ERR_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (flush) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (w_push && w_full && !pop_ok) begin
                err_overflow <= 1'b1;
            end
            if (r_pop && r_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// tb_sync_fifo : directed and randomized checks of sync_fifo against a queue model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo;

    localparam int DW    = 39;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          w_push;
    logic [DW-1:0] w_data;
    logic          w_full;
    logic          w_almost_full;
    logic          r_pop;
    logic [DW-1:0] r_data;
    logic          r_empty;
    logic          r_almost_empty;
    logic [CW-1:0] count;
`ifdef SYNC_FIFO_ERR_STICKY_EN
    logic          err_overflow;
    logic          err_underflow;
    logic          m_ovf;
    logic          m_unf;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .w_push         (w_push),
        .w_data         (w_data),
        .w_full         (w_full),
        .w_almost_full  (w_almost_full),
        .r_pop          (r_pop),
        .r_data         (r_data),
        .r_empty        (r_empty),
        .r_almost_empty (r_almost_empty),
        .count          (count)
`ifdef SYNC_FIFO_ERR_STICKY_EN
        ,
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle, then update the queue model from the FIFO rules.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic o, input logic f);
        bit pop_acc;
        bit push_acc;
        w_push = p;
        w_data = d;
        r_pop  = o;
        flush  = f;
        @(posedge clk);
        if (f) begin
            q.delete();
`ifdef SYNC_FIFO_ERR_STICKY_EN
            m_ovf = 1'b0;
            m_unf = 1'b0;
`endif
        end else begin
            pop_acc  = o && (q.size() > 0);
            push_acc = p && ((q.size() < DEPTH) || pop_acc);
`ifdef SYNC_FIFO_ERR_STICKY_EN
            if (p && !push_acc) m_ovf = 1'b1;
            if (o && q.size() == 0) m_unf = 1'b1;
`endif
            if (pop_acc) void'(q.pop_front());
            if (push_acc) q.push_back(d);
        end
        #1;
        w_push = 1'b0;
        r_pop  = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        q.delete();
`ifdef SYNC_FIFO_ERR_STICKY_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (r_empty !== 1'b1 || w_full !== 1'b0 || count !== '0 ||
            w_almost_full !== 1'b0 || r_almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: empty=%b full=%b count=%0d af=%b ae=%b, required 1 0 0 0 1",
                     r_empty, w_full, count, w_almost_full, r_almost_empty);
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] exp_v[4];
        exp_v = '{39'h11, 39'h22, 39'h33, 39'h44};
        for (int i = 0; i < 4; i++) step(1'b1, exp_v[i], 1'b0, 1'b0);
        checks++;
        if (w_full !== 1'b1 || count !== CW'(4)) begin
            failures++;
            $display("FAIL fill_full: full=%b count=%0d, required 1 4", w_full, count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r_data !== exp_v[i]) begin
                failures++;
                $display("FAIL drain_data[%0d]: got %h, required %h", i, r_data, exp_v[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (r_empty !== 1'b1 || count !== '0) begin
            failures++;
            $display("FAIL drain_empty: empty=%b count=%0d, required 1 0", r_empty, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp_v[4];
        exp_v = '{39'h22, 39'h33, 39'h44, 39'h55};
        step(1'b1, 39'h11, 1'b0, 1'b0);
        step(1'b1, 39'h22, 1'b0, 1'b0);
        step(1'b1, 39'h33, 1'b0, 1'b0);
        step(1'b1, 39'h44, 1'b0, 1'b0);
        checks++;
        if (r_data !== 39'h11) begin
            failures++;
            $display("FAIL full_pp_head: got %h, required 11", r_data);
        end
        step(1'b1, 39'h55, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(4) || w_full !== 1'b1) begin
            failures++;
            $display("FAIL full_pp_count: count=%0d full=%b, required 4 1", count, w_full);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r_data !== exp_v[i]) begin
                failures++;
                $display("FAIL full_pp_drain[%0d]: got %h, required %h", i, r_data, exp_v[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_empty_push_pop();
        w_push = 1'b1;
        w_data = 39'hAA;
        r_pop  = 1'b1;
        #1;
        checks++;
        if (r_empty !== 1'b1) begin
            failures++;
            $display("FAIL empty_pp_same_cycle: empty=%b, required 1", r_empty);
        end
        step(1'b1, 39'hAA, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(1) || r_data !== 39'hAA || r_empty !== 1'b0) begin
            failures++;
            $display("FAIL empty_pp_next: count=%0d data=%h empty=%b, required 1 aa 0",
                     count, r_data, r_empty);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_levels();
        logic exp_af;
        logic exp_ae;
        for (int n = 0; n <= 3; n++) begin
            exp_af = (n >= 3);
            exp_ae = (n <= 1);
            checks++;
            if (count !== CW'(n) || w_almost_full !== exp_af || r_almost_empty !== exp_ae) begin
                failures++;
                $display("FAIL levels[%0d]: count=%0d af=%b ae=%b, required %0d %b %b",
                         n, count, w_almost_full, r_almost_empty, n, exp_af, exp_ae);
            end
            if (n < 3) step(1'b1, DW'(n + 100), 1'b0, 1'b0);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        step(1'b1, 39'h01, 1'b0, 1'b0);
        step(1'b1, 39'h02, 1'b0, 1'b0);
        step(1'b1, 39'h77, 1'b0, 1'b1);
        checks++;
        if (count !== '0 || r_empty !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear: count=%0d empty=%b, required 0 1", count, r_empty);
        end
        step(1'b1, 39'h5A, 1'b0, 1'b0);
        checks++;
        if (r_data !== 39'h5A || count !== CW'(1)) begin
            failures++;
            $display("FAIL flush_discard: data=%h count=%0d, required 5a 1", r_data, count);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 4; i++) step(1'b1, DW'(i + 1), 1'b0, 1'b0);
        step(1'b1, 39'h99, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(4) || r_data !== 39'h1) begin
            failures++;
            $display("FAIL overflow_ignored: count=%0d data=%h, required 4 1", count, r_data);
        end
`ifdef SYNC_FIFO_ERR_STICKY_EN
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: err=%b, required 1", err_overflow);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (err_overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_flush_clear: err=%b, required 0", err_overflow);
        end
`else
        step(1'b0, '0, 1'b0, 1'b1);
`endif
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (count !== '0 || r_empty !== 1'b1) begin
            failures++;
            $display("FAIL underflow_ignored: count=%0d empty=%b, required 0 1", count, r_empty);
        end
`ifdef SYNC_FIFO_ERR_STICKY_EN
        checks++;
        if (err_underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_sticky: err=%b, required 1", err_underflow);
        end
`endif
    endtask

    task automatic test_async_reset();
        step(1'b1, 39'h31, 1'b0, 1'b0);
        step(1'b1, 39'h32, 1'b0, 1'b0);
        rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (count !== '0 || r_empty !== 1'b1 || w_full !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: count=%0d empty=%b full=%b, required 0 1 0",
                     count, r_empty, w_full);
        end
`ifdef SYNC_FIFO_ERR_STICKY_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
        checks++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_flags: ovf=%b unf=%b, required 0 0",
                     err_overflow, err_underflow);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 39'h3C, 1'b0, 1'b0);
        checks++;
        if (r_data !== 39'h3C || count !== CW'(1)) begin
            failures++;
            $display("FAIL post_reset_first: data=%h count=%0d, required 3c 1", r_data, count);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic          p;
        logic          o;
        logic          f;
        logic [DW-1:0] d;
        int            n;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45);
            f = ($urandom_range(0, 99) < 3);
            d = DW'({$urandom(), $urandom()});
            step(p, d, o, f);
            n = q.size();
            checks++;
            if (count !== CW'(n) || r_empty !== (n == 0) || w_full !== (n == DEPTH) ||
                w_almost_full !== (n >= AF) || r_almost_empty !== (n <= AE)) begin
                failures++;
                $display("FAIL rand_flags[%0d]: count=%0d empty=%b full=%b af=%b ae=%b, required count %0d",
                         i, count, r_empty, w_full, w_almost_full, r_almost_empty, n);
            end
            if (n > 0) begin
                checks++;
                if (r_data !== q[0]) begin
                    failures++;
                    $display("FAIL rand_data[%0d]: got %h, required %h", i, r_data, q[0]);
                end
            end
`ifdef SYNC_FIFO_ERR_STICKY_EN
            checks++;
            if (err_overflow !== m_ovf || err_underflow !== m_unf) begin
                failures++;
                $display("FAIL rand_err[%0d]: ovf=%b unf=%b, required %b %b",
                         i, err_overflow, err_underflow, m_ovf, m_unf);
            end
`endif
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        w_push = 1'b0;
        r_pop  = 1'b0;
        w_data = '0;
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_empty_push_pop();
        test_levels();
        test_flush();
        test_ignored();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
